// File: rtl/vec_rotate_arbiter.sv
// Round-robin front end that time-shares one combinational vec_rotate2 unit across NREQ
// requesters. Operands and results each pass through a register stage around the unit.
module vec_rotate_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*16-1:0]   req_vec_x,
    input  logic [NREQ*16-1:0]   req_vec_y,
    input  logic [NREQ*16-1:0]   req_aux_x,
    input  logic [NREQ*16-1:0]   req_aux_y,
    output logic [15:0]          rot_vec_x,
    output logic [15:0]          rot_vec_y,
    output logic [15:0]          rot_aux_x,
    output logic [15:0]          rot_aux_y,
    input  logic [15:0]          rot_magnitude,
    input  logic [15:0]          rot_aux_rot,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          rsp_magnitude,
    output logic [15:0]          rsp_aux,
    output logic [15:0]          op_count
);

    logic           s1_valid;
    logic           s2_valid;
    logic [IDW-1:0] s1_id;
    logic [IDW-1:0] s2_id;
    logic [IDW-1:0] rr_ptr;
    logic [15:0]    s2_mag;
    logic [15:0]    s2_aux;
    logic [15:0]    op_cnt;

    logic           adv1;
    logic           adv2;
    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] cand;
    logic [IDW-1:0] rr_next;
    logic [IDW+3:0] sel_base;

    assign adv2 = !s2_valid || rsp_ready;
    assign adv1 = !s1_valid || adv2;

    // First valid requester at or after rr_ptr, scanning with wrap.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IDW'((32'(rr_ptr) + k) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign rr_next  = IDW'((32'(grant_idx) + 32'd1) % NREQ);
    assign sel_base = {grant_idx, 4'b0000};

    always_comb begin
        req_ready = '0;
        if (!rst && adv1 && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s1_id     <= '0;
            s2_id     <= '0;
            rr_ptr    <= '0;
            op_cnt    <= '0;
            rot_vec_x <= '0;
            rot_vec_y <= '0;
            rot_aux_x <= '0;
            rot_aux_y <= '0;
            s2_mag    <= '0;
            s2_aux    <= '0;
        end else begin
            if (adv2) begin
                s2_valid <= s1_valid;
                s2_id    <= s1_id;
                s2_mag   <= rot_magnitude;
                s2_aux   <= rot_aux_rot;
            end
            if (adv1) begin
                if (grant_found) begin
                    s1_valid  <= 1'b1;
                    s1_id     <= grant_idx;
                    rot_vec_x <= req_vec_x[sel_base +: 16];
                    rot_vec_y <= req_vec_y[sel_base +: 16];
                    rot_aux_x <= req_aux_x[sel_base +: 16];
                    rot_aux_y <= req_aux_y[sel_base +: 16];
                    rr_ptr    <= rr_next;
                    op_cnt    <= op_cnt + 16'd1;
                end else begin
                    // Bubble: operand regs hold so the unit output does not toggle.
                    s1_valid <= 1'b0;
                end
            end
        end
    end

    assign rsp_valid     = s2_valid;
    assign rsp_id        = s2_id;
    assign rsp_magnitude = s2_mag;
    assign rsp_aux       = s2_aux;
    assign op_count      = op_cnt;

endmodule
